// File: rtl/matrix_bank_mem.sv
// Three-bank (A/B/C) row-major matrix store: streaming load, registered random read,
// direct C write and streaming C dump. Optional parity storage: MATMEM_PARITY_EN.
module matrix_bank_mem #(
  parameter int DW      = 8,
  parameter int MAX_DIM = 16,
  parameter int IW      = $clog2(MAX_DIM),
  parameter int AW      = $clog2(MAX_DIM * MAX_DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [IW:0]   cfg_dim,
  output logic [IW:0]   dim,
  input  logic          ld_start,
  input  logic [1:0]    ld_bank,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  output logic          ld_done,
  input  logic          rd_en,
  input  logic [1:0]    rd_bank,
  input  logic [IW-1:0] rd_row,
  input  logic [IW-1:0] rd_col,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_row,
  input  logic [IW-1:0] wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic          dump_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          rd_perr
);

  localparam int          DEPTH = MAX_DIM * MAX_DIM;
  localparam logic [IW:0] MAXD  = (IW + 1)'(MAX_DIM);

`ifdef MATMEM_PARITY_EN
  localparam int MW = DW + 1;
  function automatic logic [MW-1:0] enc(input logic [DW-1:0] d);
    return {^d, d};
  endfunction
`else
  localparam int MW = DW;
  function automatic logic [MW-1:0] enc(input logic [DW-1:0] d);
    return d;
  endfunction
`endif

  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] row, input logic [IW-1:0] col,
                                            input logic [IW:0] d);
    return AW'(row) * AW'(d) + AW'(col);
  endfunction

  function automatic logic in_range(input logic [IW-1:0] row, input logic [IW-1:0] col,
                                    input logic [IW:0] d);
    return ({1'b0, row} < d) && ({1'b0, col} < d);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP} state_t;

  state_t        r_state;
  logic [IW:0]   r_dim;
  logic [IW-1:0] r_row, r_col;
  logic [1:0]    r_bank;
  logic          r_ld_done, r_out_valid, r_out_last, r_rd_valid;
  logic [DW-1:0] r_out_data, r_rd_data;

  logic [MW-1:0] r_mem_a [DEPTH];
  logic [MW-1:0] r_mem_b [DEPTH];
  logic [MW-1:0] r_mem_c [DEPTH];

  logic [IW:0]   w_dm1;
  logic          w_col_end, w_row_end, w_nlast;
  logic [IW-1:0] w_nrow, w_ncol;
  logic [AW-1:0] w_cur_addr, w_nxt_addr, w_wr_addr, w_rd_addr, w_dump_addr;
  logic          w_wr_ok, w_rd_ok, w_ld_go, w_dump_go, w_ld_fire, w_out_fire;
  logic [MW-1:0] w_rd_word, w_dump_word;

  // r_row/r_col: next write slot during LOAD, currently presented element during DUMP
  assign w_dm1      = r_dim - 1'b1;
  assign w_col_end  = ({1'b0, r_col} == w_dm1);
  assign w_row_end  = ({1'b0, r_row} == w_dm1);
  assign w_ncol     = w_col_end ? '0 : r_col + 1'b1;
  assign w_nrow     = w_col_end ? r_row + 1'b1 : r_row;
  assign w_nlast    = ({1'b0, w_nrow} == w_dm1) && ({1'b0, w_ncol} == w_dm1);
  assign w_cur_addr = addr_of(r_row, r_col, r_dim);
  assign w_nxt_addr = addr_of(w_nrow, w_ncol, r_dim);

  assign w_wr_ok   = wr_en && in_range(wr_row, wr_col, r_dim);
  assign w_wr_addr = addr_of(wr_row, wr_col, r_dim);
  assign w_rd_ok   = (rd_bank != 2'b11) && in_range(rd_row, rd_col, r_dim);
  assign w_rd_addr = addr_of(rd_row, rd_col, r_dim);

  assign w_ld_go    = (r_state == S_IDLE) && ld_start && (ld_bank != 2'b11);
  assign w_dump_go  = (r_state == S_IDLE) && dump_start && !w_ld_go;
  assign ld_ready   = (r_state == S_LOAD) && !(wr_en && (r_bank == 2'b10));
  assign w_ld_fire  = ld_ready && ld_valid;
  assign w_out_fire = (r_state == S_DUMP) && r_out_valid && out_ready;

  always_comb begin
    w_rd_word = '0;
    case (rd_bank)
      2'b00:   w_rd_word = r_mem_a[w_rd_addr];
      2'b01:   w_rd_word = r_mem_b[w_rd_addr];
      2'b10:   w_rd_word = r_mem_c[w_rd_addr];
      default: w_rd_word = '0;
    endcase
  end

  // A MAC write landing on the element being fetched is forwarded so it is never lost
  assign w_dump_addr = (r_state == S_IDLE) ? '0 : w_nxt_addr;
  always_comb begin
    w_dump_word = r_mem_c[w_dump_addr];
    if (w_wr_ok && (w_wr_addr == w_dump_addr)) w_dump_word = enc(wr_data);
  end

  always_ff @(posedge clk) begin
    if (w_ld_fire && (r_bank == 2'b00)) r_mem_a[w_cur_addr] <= enc(ld_data);
    if (w_ld_fire && (r_bank == 2'b01)) r_mem_b[w_cur_addr] <= enc(ld_data);
    if (w_wr_ok)                        r_mem_c[w_wr_addr]  <= enc(wr_data);
    else if (w_ld_fire && (r_bank == 2'b10)) r_mem_c[w_cur_addr] <= enc(ld_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dim       <= MAXD;
      r_row       <= '0;
      r_col       <= '0;
      r_bank      <= 2'b00;
      r_ld_done   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_ld_done  <= 1'b0;
      r_rd_valid <= rd_en;
      r_rd_data  <= (rd_en && w_rd_ok) ? w_rd_word[DW-1:0] : '0;
      case (r_state)
        S_IDLE: begin
          if (cfg_we && (cfg_dim != '0)) r_dim <= (cfg_dim > MAXD) ? MAXD : cfg_dim;
          if (w_ld_go) begin
            r_state <= S_LOAD;
            r_bank  <= ld_bank;
            r_row   <= '0;
            r_col   <= '0;
          end else if (w_dump_go) begin
            r_state     <= S_DUMP;
            r_row       <= '0;
            r_col       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_dump_word[DW-1:0];
            r_out_last  <= (r_dim == (IW + 1)'(1));
          end
        end
        S_LOAD: begin
          if (w_ld_fire) begin
            r_row <= w_nrow;
            r_col <= w_ncol;
            if (w_row_end && w_col_end) begin
              r_state   <= S_IDLE;
              r_ld_done <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (w_out_fire) begin
            if (r_out_last) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_row      <= w_nrow;
              r_col      <= w_ncol;
              r_out_data <= w_dump_word[DW-1:0];
              r_out_last <= w_nlast;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MATMEM_PARITY_EN
  logic r_rd_perr, r_dump_perr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_perr   <= 1'b0;
      r_dump_perr <= 1'b0;
    end else begin
      r_rd_perr <= rd_en && w_rd_ok && (^w_rd_word);
      // sticky across the dump; a new dump_start clears it and checks C[0]
      if (w_dump_go) r_dump_perr <= ^w_dump_word;
      else if (w_out_fire && !r_out_last && (^w_dump_word)) r_dump_perr <= 1'b1;
    end
  end
  assign rd_perr = r_rd_perr | r_dump_perr;
`else
  assign rd_perr = 1'b0;
`endif

  assign dim       = r_dim;
  assign ld_done   = r_ld_done;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_matrix_bank_mem.sv
// Directed self-checking bench for matrix_bank_mem: load, read, MAC write, dump,
// dimension config, out-of-range handling and mid-operation reset.
module tb_matrix_bank_mem;
  localparam int DW      = 8;
  localparam int MAX_DIM = 16;
  localparam int IW      = $clog2(MAX_DIM);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [IW:0]   cfg_dim;
  logic [IW:0]   dim;
  logic          ld_start;
  logic [1:0]    ld_bank;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_done;
  logic          rd_en;
  logic [1:0]    rd_bank;
  logic [IW-1:0] rd_row, rd_col;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [IW-1:0] wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic          dump_start;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          rd_perr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  matrix_bank_mem #(.DW(DW), .MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_dim(cfg_dim), .dim(dim),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_done(ld_done),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .dump_start(dump_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .rd_perr(rd_perr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_dim(input int d);
    cfg_we  = 1'b1;
    cfg_dim = (IW + 1)'(d);
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic do_write(input int row, input int col, input int data);
    wr_en   = 1'b1;
    wr_row  = IW'(row);
    wr_col  = IW'(col);
    wr_data = DW'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input string tag, input int bank, input int row, input int col,
                         input int exp);
    rd_en   = 1'b1;
    rd_bank = 2'(bank);
    rd_row  = IW'(row);
    rd_col  = IW'(col);
    tick();
    rd_en   = 1'b0;
    check_eq({tag, "_valid"}, rd_valid, 1);
    check_eq({tag, "_data"}, rd_data, exp);
  endtask

  task automatic start_dump();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  initial begin
    logic [4:0] rdy_pat;
    rst = 1'b1; cfg_we = 0; cfg_dim = '0; ld_start = 0; ld_bank = 0; ld_valid = 0;
    ld_data = '0; rd_en = 0; rd_bank = 0; rd_row = '0; rd_col = '0; wr_en = 0;
    wr_row = '0; wr_col = '0; wr_data = '0; dump_start = 0; out_ready = 0;
    #2;
    check_eq("rst_dim", dim, MAX_DIM);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ld_ready", ld_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_ld_done", ld_done, 0);
    repeat (2) tick();
    rst = 1'b0;

    // 1: dim 3, stream 1..9 into A
    set_dim(3);
    check_eq("dim3", dim, 3);
    ld_start = 1'b1; ld_bank = 2'b00;
    tick();
    ld_start = 1'b0;
    check_eq("load_busy", busy, 1);
    check_eq("load_ready", ld_ready, 1);
    ld_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      ld_data = DW'(i);
      tick();
      if (i == 8) begin
        check_eq("ld_done_early", ld_done, 0);
        check_eq("busy_before_last", busy, 1);
      end
    end
    ld_valid = 1'b0;
    check_eq("ld_done_pulse", ld_done, 1);
    check_eq("idle_after_load", busy, 0);
    tick();
    check_eq("ld_done_one_cycle", ld_done, 0);
    do_read("rdA12", 0, 1, 2, 6);
    do_read("rdA00", 0, 0, 0, 1);
    do_read("rdA22", 0, 2, 2, 9);

    // reserved load bank is ignored
    ld_start = 1'b1; ld_bank = 2'b11;
    tick();
    ld_start = 1'b0;
    check_eq("bank3_ignored", busy, 0);

    // 5: out-of-range read/write with dim 3
    do_write(1, 0, 8'h11);
    do_write(0, 3, 8'hBB);
    do_write(3, 0, 8'hAA);
    do_read("rdC10_kept", 2, 1, 0, 8'h11);
    do_read("rd_oor_row", 2, 3, 0, 0);
    do_read("rd_bank3", 3, 1, 0, 0);

    // 2: dimension config edge cases
    set_dim(0);
    check_eq("dim_zero_ignored", dim, 3);
    set_dim(20);
    check_eq("dim_saturate", dim, MAX_DIM);

    // 3: load C with 4,3,2,1 while a MAC write hits C(0,1)
    set_dim(2);
    ld_start = 1'b1; ld_bank = 2'b10;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'd4;
    tick();
    ld_data = 8'd3; wr_en = 1'b1; wr_row = 0; wr_col = 1; wr_data = 8'd9;
    #1;
    check_eq("ld_ready_blocked", ld_ready, 0);
    tick();
    wr_en = 1'b0; cfg_we = 1'b1; cfg_dim = 1;
    #1;
    check_eq("ld_ready_resumed", ld_ready, 1);
    tick();
    cfg_we = 1'b0;
    ld_data = 8'd2;
    tick();
    check_eq("ld_done_not_yet", ld_done, 0);
    ld_data = 8'd1;
    tick();
    ld_valid = 1'b0;
    check_eq("ldC_done", ld_done, 1);
    check_eq("dim_held_in_load", dim, 2);
    do_read("rdC01", 2, 0, 1, 3);
    do_read("rdC00", 2, 0, 0, 4);
    do_read("rdC11", 2, 1, 1, 1);

    // 4: dump with out_ready toggling
    do_write(0, 0, 5); do_write(0, 1, 6); do_write(1, 0, 7); do_write(1, 1, 8);
    exp_q = '{8'd5, 8'd6, 8'd7, 8'd8};
    start_dump();
    rdy_pat = 5'b11101;
    for (int k = 0; k < 5; k++) begin
      out_ready = rdy_pat[k];
      check_eq($sformatf("dump%0d_valid", k), out_valid, 1);
      check_eq($sformatf("dump%0d_data", k), out_data, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
      check_eq($sformatf("dump%0d_last", k), out_last, (exp_q.size() == 1) ? 1 : 0);
      if (rdy_pat[k] && exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
    end
    out_ready = 1'b0;
    check_eq("dump_drained", exp_q.size(), 0);
    check_eq("dump_end_valid", out_valid, 0);
    check_eq("dump_end_busy", busy, 0);

    // dump at full rate with a MAC write to the element fetched next
    exp_q = '{8'd5, 8'h33, 8'd7, 8'd8};
    start_dump();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        wr_en = 1'b1; wr_row = 0; wr_col = 1; wr_data = 8'h33;
      end
      check_eq($sformatf("fdump%0d_valid", k), out_valid, 1);
      check_eq($sformatf("fdump%0d_data", k), out_data, exp_q[0]);
      check_eq($sformatf("fdump%0d_last", k), out_last, (k == 3) ? 1 : 0);
      void'(exp_q.pop_front());
      tick();
      wr_en = 1'b0;
    end
    out_ready = 1'b0;
    check_eq("fdump_end_busy", busy, 0);

    // 6: reset in the middle of a load
    ld_start = 1'b1; ld_bank = 2'b00;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h21;
    tick();
    ld_data = 8'h22;
    tick();
    ld_valid = 1'b0;
    check_eq("mid_load_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_ready", ld_ready, 0);
    check_eq("rst_mid_dim", dim, MAX_DIM);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ld_start = 1'b1; ld_bank = 2'b01; dump_start = 1'b1;
    tick();
    ld_start = 1'b0; dump_start = 1'b0;
    check_eq("restart_busy", busy, 1);
    check_eq("restart_ld_ready", ld_ready, 1);
    check_eq("ld_beats_dump", out_valid, 0);
    do_read("partial_A00", 0, 0, 0, 8'h21);
    do_read("partial_A01", 0, 0, 1, 8'h22);
    check_eq("no_perr", rd_perr, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
